l1_buffer_pingpong: RTL and testbench

Double-buffered L1 operand buffer with independent per-lane read indices. A producer (DMA/loader) fills one bank with lane-wide rows while the compute array drains the other bank, each lane reading its own row index. Bank ownership is exchanged by explicit commit/release handshakes, so load and compute overlap without stalls. It replaces the single-bank L1 buffer where read and write previously had to be time-multiplexed.

---
 rtl/l1_buffer_pingpong_if.sv | 36 +++
 rtl/l1_buffer_pingpong.sv | 94 +++++++++
 tb/tb_l1_buffer_pingpong.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/l1_buffer_pingpong_if.sv
// rtl/l1_buffer_pingpong_if.sv - write/read bus bundle for the ping-pong L1 operand buffer
interface l1_buffer_pingpong_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LANE_COUNT = 4,
  parameter int DATA_DEPTH = 16
);
  localparam int IW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;

  // Fill side (producer)
  logic                                  write_valid;
  logic                                  write_ready;
  logic [IW-1:0]                         write_index;
  logic [LANE_COUNT-1:0][DATA_WIDTH-1:0] data_in;
  logic                                  write_commit;

  // Drain side (compute lanes)
  logic                                  read_bank_valid;
  logic [LANE_COUNT-1:0]                 read_enable;
  logic [LANE_COUNT-1:0][IW-1:0]         read_index;
  logic                                  read_release;
  logic [LANE_COUNT-1:0][DATA_WIDTH-1:0] data_out;
  logic [LANE_COUNT-1:0]                 data_valid;
  logic [1:0]                            bank_count;

  modport master (
    output write_valid, write_index, data_in, write_commit,
    output read_enable, read_index, read_release,
    input  write_ready, read_bank_valid, data_out, data_valid, bank_count
  );

  modport slave (
    input  write_valid, write_index, data_in, write_commit,
    input  read_enable, read_index, read_release,
    output write_ready, read_bank_valid, data_out, data_valid, bank_count
  );
endinterface

// File: rtl/l1_buffer_pingpong.sv
// rtl/l1_buffer_pingpong.sv - double-buffered L1 operand buffer with per-lane read indices
module l1_buffer_pingpong #(
  parameter int DATA_WIDTH = 8,
  parameter int LANE_COUNT = 4,
  parameter int DATA_DEPTH = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  l1_buffer_pingpong_if.slave bus
);
  localparam int IW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  // Depth widened by one bit so the range compare never truncates.
  localparam logic [IW:0] DEPTH_W = (IW + 1)'(DATA_DEPTH);

  typedef logic [LANE_COUNT-1:0][DATA_WIDTH-1:0] row_t;

  // Bank storage; never reset, contents survive commit/release.
  row_t mem_q [2][DATA_DEPTH];

  // Ownership state: bit set means the bank is FULL.
  logic [1:0]            state_q, state_d;
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  row_t                  data_out_q, data_out_d;
  logic [LANE_COUNT-1:0] data_valid_q, data_valid_d;

  logic write_ready_w;
  logic read_bank_valid_w;
  logic wr_fire_w;

  // Handshake outputs depend on registered state only.
  assign write_ready_w     = ~state_q[wr_bank_q];
  assign read_bank_valid_w = state_q[rd_bank_q];
  assign wr_fire_w         = bus.write_valid && write_ready_w &&
                             ({1'b0, bus.write_index} < DEPTH_W);

  assign bus.write_ready     = write_ready_w;
  assign bus.read_bank_valid = read_bank_valid_w;
  assign bus.data_out        = data_out_q;
  assign bus.data_valid      = data_valid_q;
  assign bus.bank_count      = 2'(state_q[0]) + 2'(state_q[1]);

  // Commit fills the writer's bank, release frees the reader's bank; they never collide.
  always_comb begin
    state_d   = state_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    if (bus.write_commit && write_ready_w) begin
      state_d[wr_bank_q] = 1'b1;
      wr_bank_d          = ~wr_bank_q;
    end
    if (bus.read_release && read_bank_valid_w) begin
      state_d[rd_bank_q] = 1'b0;
      rd_bank_d          = ~rd_bank_q;
    end
  end

  // Each lane independently looks up its own row in the drain bank.
  always_comb begin
    data_out_d   = '0;
    data_valid_d = '0;
    for (int l = 0; l < LANE_COUNT; l++) begin
      if (bus.read_enable[l] && read_bank_valid_w &&
          ({1'b0, bus.read_index[l]} < DEPTH_W)) begin
        data_valid_d[l] = 1'b1;
        data_out_d[l]   = mem_q[rd_bank_q][bus.read_index[l]][l];
      end
    end
  end

  // Ownership pointers and registered read results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  // Row write lands in the current fill bank, including the committing one.
  always_ff @(posedge clk) begin
    if (wr_fire_w) begin
      mem_q[wr_bank_q][bus.write_index] <= bus.data_in;
    end
  end
endmodule

// File: tb/tb_l1_buffer_pingpong.sv
// tb/tb_l1_buffer_pingpong.sv - directed self-checking bench for l1_buffer_pingpong
module tb_l1_buffer_pingpong;
  localparam int DW = 8;
  localparam int LC = 4;
  localparam int DD = 12;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  l1_buffer_pingpong_if #(.DATA_WIDTH(DW), .LANE_COUNT(LC), .DATA_DEPTH(DD)) bus ();

  l1_buffer_pingpong #(.DATA_WIDTH(DW), .LANE_COUNT(LC), .DATA_DEPTH(DD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_reads(input logic [3:0] en, input int i0, input int i1,
                           input int i2, input int i3);
    bus.read_enable   = en;
    bus.read_index[0] = 4'(i0);
    bus.read_index[1] = 4'(i1);
    bus.read_index[2] = 4'(i2);
    bus.read_index[3] = 4'(i3);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.write_valid  = 1'b0;
    bus.write_index  = '0;
    bus.data_in      = '0;
    bus.write_commit = 1'b0;
    bus.read_release = 1'b0;
    set_reads(4'b0000, 0, 0, 0, 0);
    step();
    step();
    chk("rst_write_ready", 32'(bus.write_ready), 32'h1);
    chk("rst_rbv", 32'(bus.read_bank_valid), 32'h0);
    chk("rst_bank_count", 32'(bus.bank_count), 32'h0);
    chk("rst_data_valid", 32'(bus.data_valid), 32'h0);
    chk("rst_data_out", 32'(bus.data_out), 32'h0);
    rst_n = 1'b1;
    step();

    // Fill bank0: row r lane l = r*16 + l
    for (int r = 0; r < DD; r++) begin
      bus.write_valid = 1'b1;
      bus.write_index = 4'(r);
      for (int l = 0; l < LC; l++) bus.data_in[l] = 8'(r * 16 + l);
      step();
    end
    bus.write_valid = 1'b0;
    chk("fill0_rbv_low", 32'(bus.read_bank_valid), 32'h0);
    bus.write_commit = 1'b1;
    step();
    bus.write_commit = 1'b0;
    chk("commit0_rbv", 32'(bus.read_bank_valid), 32'h1);
    chk("commit0_count", 32'(bus.bank_count), 32'h1);
    chk("commit0_wready", 32'(bus.write_ready), 32'h1);

    set_reads(4'b1111, 3, 7, 0, 11);
    step();
    chk("read0_data", 32'(bus.data_out), 32'hB302_7130);
    chk("read0_valid", 32'(bus.data_valid), 32'hF);

    // Out-of-range index on lane 2, lane 3 disabled
    set_reads(4'b0111, 5, 7, 12, 11);
    step();
    chk("bound_data", 32'(bus.data_out), 32'h0000_7150);
    chk("bound_valid", 32'(bus.data_valid), 32'h3);

    // Fill bank1 (row r lane l = r*16 + l + 8) while lane0 drains bank0
    for (int r = 0; r < DD; r++) begin
      bus.write_valid = 1'b1;
      bus.write_index = 4'(r);
      for (int l = 0; l < LC; l++) bus.data_in[l] = 8'(r * 16 + l + 8);
      set_reads(4'b0001, r, 0, 0, 0);
      step();
      chk("overlap_lane0", 32'(bus.data_out), 32'(r * 16));
    end
    bus.write_valid = 1'b0;
    set_reads(4'b0000, 0, 0, 0, 0);
    bus.write_commit = 1'b1;
    step();
    chk("commit1_count", 32'(bus.bank_count), 32'h2);
    chk("commit1_wready", 32'(bus.write_ready), 32'h0);
    chk("commit1_rbv", 32'(bus.read_bank_valid), 32'h1);

    // Write and commit while no bank is free: ignored
    bus.write_valid = 1'b1;
    bus.write_index = 4'd0;
    bus.data_in     = 32'hFFFF_FFFF;
    step();
    bus.write_valid  = 1'b0;
    bus.write_commit = 1'b0;
    chk("full_ign_count", 32'(bus.bank_count), 32'h2);
    chk("full_ign_wready", 32'(bus.write_ready), 32'h0);
    set_reads(4'b1111, 0, 0, 0, 0);
    step();
    chk("full_ign_row0", 32'(bus.data_out), 32'h0302_0100);

    // Read in the release cycle samples the releasing bank
    set_reads(4'b0001, 5, 0, 0, 0);
    bus.read_release = 1'b1;
    step();
    bus.read_release = 1'b0;
    chk("relread_data", 32'(bus.data_out), 32'h0000_0050);
    chk("relread_valid", 32'(bus.data_valid), 32'h1);
    chk("rel_rbv", 32'(bus.read_bank_valid), 32'h1);
    chk("rel_count", 32'(bus.bank_count), 32'h1);
    chk("rel_wready", 32'(bus.write_ready), 32'h1);

    set_reads(4'b1111, 0, 1, 2, 11);
    step();
    chk("read1_data", 32'(bus.data_out), 32'hBB2A_1908);
    chk("read1_valid", 32'(bus.data_valid), 32'hF);

    // Out-of-range write into the free bank: dropped, no side effect
    set_reads(4'b0000, 0, 0, 0, 0);
    bus.write_valid = 1'b1;
    bus.write_index = 4'd13;
    bus.data_in     = 32'hEEEE_EEEE;
    step();
    chk("oor_wr_wready", 32'(bus.write_ready), 32'h1);
    chk("oor_wr_count", 32'(bus.bank_count), 32'h1);

    // Write + commit + release in one cycle
    bus.write_index  = 4'd4;
    bus.data_in      = 32'h4443_4241;
    bus.write_commit = 1'b1;
    bus.read_release = 1'b1;
    step();
    bus.write_valid  = 1'b0;
    bus.write_commit = 1'b0;
    bus.read_release = 1'b0;
    chk("swap_count", 32'(bus.bank_count), 32'h1);
    chk("swap_wready", 32'(bus.write_ready), 32'h1);
    chk("swap_rbv", 32'(bus.read_bank_valid), 32'h1);
    set_reads(4'b1111, 4, 4, 4, 3);
    step();
    chk("swap_read", 32'(bus.data_out), 32'h3343_4241);

    // Release last full bank, then reads with no readable bank
    set_reads(4'b0000, 0, 0, 0, 0);
    bus.read_release = 1'b1;
    step();
    bus.read_release = 1'b0;
    chk("empty_count", 32'(bus.bank_count), 32'h0);
    chk("empty_rbv", 32'(bus.read_bank_valid), 32'h0);
    chk("empty_wready", 32'(bus.write_ready), 32'h1);
    set_reads(4'b1111, 0, 0, 0, 0);
    step();
    chk("norbv_valid", 32'(bus.data_valid), 32'h0);
    chk("norbv_data", 32'(bus.data_out), 32'h0);

    // Commit with no writes exposes old bank1 contents
    bus.write_commit = 1'b1;
    step();
    bus.write_commit = 1'b0;
    chk("blank_commit_rbv", 32'(bus.read_bank_valid), 32'h1);
    step();
    chk("blank_commit_data", 32'(bus.data_out), 32'h0B0A_0908);
    chk("blank_commit_valid", 32'(bus.data_valid), 32'hF);

    // Asynchronous reset mid-operation
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.data_valid), 32'h0);
    chk("arst_data", 32'(bus.data_out), 32'h0);
    chk("arst_count", 32'(bus.bank_count), 32'h0);
    chk("arst_wready", 32'(bus.write_ready), 32'h1);
    chk("arst_rbv", 32'(bus.read_bank_valid), 32'h0);
    step();
    chk("arst_hold_valid", 32'(bus.data_valid), 32'h0);
    rst_n = 1'b1;
    set_reads(4'b0000, 0, 0, 0, 0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
